// File: rtl/pet_pkg.sv
// Shared types and the fixed slot map for the SRAM time-slot arbiter.
package pet_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_VIDEO,
        OWN_BRIDGE
    } owner_t;

    // Raw slot kinds; the *_BRG kinds resolve by column mode.
    typedef enum logic [2:0] {
        SK_CPU,
        SK_BRG,
        SK_VRAM,
        SK_VROM,
        SK_VRAM_BRG,
        SK_VROM_BRG
    } slot_kind_t;

    localparam int         SLOTS_PER_FRAME = 8;
    localparam logic [2:0] SLOT_CPU        = 3'd0;

    localparam slot_kind_t SLOT_MAP [SLOTS_PER_FRAME] = '{
        SK_CPU, SK_BRG, SK_VRAM, SK_VROM, SK_BRG, SK_VRAM_BRG, SK_VROM_BRG, SK_BRG
    };

    // Resolve a slot to its effective owner class for the given column mode.
    function automatic slot_kind_t slot_kind(input logic [2:0] slot, input logic col80);
        slot_kind_t k;
        k = SLOT_MAP[slot];
        if (k == SK_VRAM_BRG)      k = col80 ? SK_VRAM : SK_BRG;
        else if (k == SK_VROM_BRG) k = col80 ? SK_VROM : SK_BRG;
        return k;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shared SRAM scheduler: 16-cycle frame of 8 two-cycle slots (setup, strobe),
// owner mux for CPU / video / bridge, and the per-slot enable pulses.
// cnt_q holds the c value whose outputs get registered at the next edge, so the
// visible outputs always describe the current c.
module mem_arbiter
    import pet_pkg::*;
#(
    parameter bit COL80  = 1'b0,
    parameter int ADDR_W = 17
) (
    input  logic              clk16_i,
    input  logic              reset_n_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_we_i,
    input  logic [7:0]        cpu_wdata_i,
    input  logic [ADDR_W-1:0] video_addr_i,
    input  logic              bridge_req_i,
    input  logic              bridge_we_i,
    input  logic [ADDR_W-1:0] bridge_addr_i,
    input  logic [7:0]        bridge_wdata_i,
    output logic              bridge_ack_o,
    output logic [7:0]        bridge_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_data_i,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o,
    output logic              setup_clk_o,
    output logic              strobe_clk_o,
    output logic              cpu_en_o,
    output logic              vram_en_o,
    output logic              vrom_en_o
);

    logic [3:0]        cnt_q;
    logic              phase;
    logic [2:0]        slot;
    slot_kind_t        kind;

    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              setup_q, strobe_q, cpu_en_q, vram_en_q, vrom_en_q, ack_q;
    logic              oe_n_q, we_n_q, oe_n_d, we_n_d, ack_d;

    assign phase = cnt_q[0];
    assign slot  = cnt_q[3:1];
    assign kind  = slot_kind(slot, COL80);

    // Owner, direction, address and data latch at setup and hold through strobe.
    always_comb begin
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (!phase) begin
            owner_d = OWN_NONE;
            we_d    = 1'b0;
            case (kind)
                SK_CPU: begin
                    owner_d = OWN_CPU;
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
                end
                SK_VRAM, SK_VROM: begin
                    owner_d = OWN_VIDEO;
                    addr_d  = video_addr_i;
                end
                SK_BRG: begin
                    if (bridge_req_i) begin
                        owner_d = OWN_BRIDGE;
                        we_d    = bridge_we_i;
                        addr_d  = bridge_addr_i;
                        wdata_d = bridge_wdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes and bridge completion; owner_q still names the slot that just ended at a setup edge.
    always_comb begin
        oe_n_d  = !((owner_d != OWN_NONE) && !we_d);
        we_n_d  = !(phase && (owner_d != OWN_NONE) && we_d);
        ack_d   = !phase && (owner_q == OWN_BRIDGE);
        rdata_d = rdata_q;
        if (!phase && (owner_q == OWN_BRIDGE) && !we_q) rdata_d = ram_data_i;
    end

    // Frame counter and every registered output.
    always_ff @(posedge clk16_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q     <= 4'd0;
            owner_q   <= OWN_NONE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            setup_q   <= 1'b0;
            strobe_q  <= 1'b0;
            cpu_en_q  <= 1'b0;
            vram_en_q <= 1'b0;
            vrom_en_q <= 1'b0;
            ack_q     <= 1'b0;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
        end else begin
            cnt_q     <= cnt_q + 4'd1;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            setup_q   <= !phase;
            strobe_q  <= phase;
            cpu_en_q  <= phase && (slot == SLOT_CPU);
            vram_en_q <= phase && (kind == SK_VRAM);
            vrom_en_q <= phase && (kind == SK_VROM);
            ack_q     <= ack_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
        end
    end

    assign bridge_ack_o   = ack_q;
    assign bridge_rdata_o = rdata_q;
    assign ram_addr_o     = addr_q;
    assign ram_wdata_o    = wdata_q;
    assign ram_oe_n_o     = oe_n_q;
    assign ram_we_n_o     = we_n_q;
    assign setup_clk_o    = setup_q;
    assign strobe_clk_o   = strobe_q;
    assign cpu_en_o       = cpu_en_q;
    assign vram_en_o      = vram_en_q;
    assign vrom_en_o      = vrom_en_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: u0 runs 40-col (COL80=0), u1 runs 80-col (COL80=1) with the bridge
// and a model SRAM. Stimulus pushes expected events tagged with the bench cycle count tc;
// a negedge monitor pops and compares whenever the DUT shows an event.
module tb_mem_arbiter;

    localparam int K_CPU0 = 0, K_VRAM0 = 1, K_VROM0 = 2, K_VRAM1 = 3, K_VROM1 = 4;
    localparam int K_OE = 5, K_WE = 6, K_ACK = 7;

    typedef struct {
        int          kind;
        int          tc;
        logic [16:0] addr;
        logic [7:0]  data;
        bit          chk;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tc = -1;
    bit pat_on = 1'b0;
    ev_t qe[$];
    ev_t qb[$];

    logic [16:0] cpu_addr = 17'h00100;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we0 = 1'b0;
    logic [16:0] video_addr = 17'h04000;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [16:0] b_addr = '0;
    logic [7:0]  b_wdata = '0;

    logic        pre_we = 1'b0;
    logic [16:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    bit   [7:0]  mem [0:131071];

    logic        u0_ack, u0_oe_n, u0_we_n, u0_setup, u0_strobe, u0_cpu_en, u0_vram_en, u0_vrom_en;
    logic [7:0]  u0_rdata, u0_wdata;
    logic [16:0] u0_addr;
    logic        u1_ack, u1_oe_n, u1_we_n, u1_setup, u1_strobe, u1_cpu_en, u1_vram_en, u1_vrom_en;
    logic [7:0]  u1_rdata, u1_wdata, ram_rd1;
    logic [16:0] u1_addr;

    assign ram_rd1 = mem[u1_addr];

    mem_arbiter #(.COL80(1'b0), .ADDR_W(17)) u0 (
        .clk16_i(clk), .reset_n_i(rst_n),
        .cpu_addr_i(cpu_addr), .cpu_we_i(cpu_we0), .cpu_wdata_i(cpu_wdata),
        .video_addr_i(video_addr),
        .bridge_req_i(1'b0), .bridge_we_i(1'b0), .bridge_addr_i(17'h0), .bridge_wdata_i(8'h00),
        .bridge_ack_o(u0_ack), .bridge_rdata_o(u0_rdata),
        .ram_addr_o(u0_addr), .ram_wdata_o(u0_wdata), .ram_data_i(8'h00),
        .ram_oe_n_o(u0_oe_n), .ram_we_n_o(u0_we_n),
        .setup_clk_o(u0_setup), .strobe_clk_o(u0_strobe),
        .cpu_en_o(u0_cpu_en), .vram_en_o(u0_vram_en), .vrom_en_o(u0_vrom_en)
    );

    mem_arbiter #(.COL80(1'b1), .ADDR_W(17)) u1 (
        .clk16_i(clk), .reset_n_i(rst_n),
        .cpu_addr_i(cpu_addr), .cpu_we_i(1'b0), .cpu_wdata_i(cpu_wdata),
        .video_addr_i(video_addr),
        .bridge_req_i(b_req), .bridge_we_i(b_we), .bridge_addr_i(b_addr), .bridge_wdata_i(b_wdata),
        .bridge_ack_o(u1_ack), .bridge_rdata_o(u1_rdata),
        .ram_addr_o(u1_addr), .ram_wdata_o(u1_wdata), .ram_data_i(ram_rd1),
        .ram_oe_n_o(u1_oe_n), .ram_we_n_o(u1_we_n),
        .setup_clk_o(u1_setup), .strobe_clk_o(u1_strobe),
        .cpu_en_o(u1_cpu_en), .vram_en_o(u1_vram_en), .vrom_en_o(u1_vrom_en)
    );

    // Bench cycle count: 0 in the first cycle after reset release, so c = tc % 16.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tc <= -1;
        else        tc <= tc + 1;
    end

    // Model SRAM: bench presets, otherwise written by u1 at the edge ending a WE-low cycle.
    always @(posedge clk) begin
        if (pre_we)                      mem[pre_addr] <= pre_data;
        else if (rst_n && !u1_we_n)      mem[u1_addr] <= u1_wdata;
    end

    function automatic string kname(input int k);
        case (k)
            K_CPU0:  return "u0_cpu_en";
            K_VRAM0: return "u0_vram_en";
            K_VROM0: return "u0_vrom_en";
            K_VRAM1: return "u1_vram_en";
            K_VROM1: return "u1_vrom_en";
            K_OE:    return "brg_oe";
            K_WE:    return "brg_we";
            default: return "brg_ack";
        endcase
    endfunction

    // Bridge slots of the 80-column unit: slots 1, 4, 7.
    function automatic bit brg_slot1(input int c);
        return (c / 2 == 1) || (c / 2 == 4) || (c / 2 == 7);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (tc=%0d)", nm, act, exp, tc);
        end
    endtask

    task automatic push(input bit brg, input int kind, input int t,
                        input logic [16:0] a, input logic [7:0] d, input bit chk);
        ev_t e;
        e.kind = kind; e.tc = t; e.addr = a; e.data = d; e.chk = chk;
        if (brg) qb.push_back(e);
        else     qe.push_back(e);
    endtask

    task automatic obs(input bit brg, input int kind, input logic [16:0] a, input logic [7:0] d);
        ev_t e;
        checks++;
        if (brg ? (qb.size() == 0) : (qe.size() == 0)) begin
            failures++;
            $display("FAIL %s unexpected event at tc=%0d addr=%h data=%h", kname(kind), tc, a, d);
        end else begin
            if (brg) e = qb.pop_front();
            else     e = qe.pop_front();
            if (e.kind != kind || e.tc != tc || (e.chk && (e.addr !== a || e.data !== d))) begin
                failures++;
                $display("FAIL %s got tc=%0d addr=%h data=%h, expected %s tc=%0d addr=%h data=%h",
                         kname(kind), tc, a, d, kname(e.kind), e.tc, e.addr, e.data);
            end
        end
    endtask

    // Monitor: pop and compare whenever an output event is visible.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tc >= 0) begin
            while (qb.size() > 0 && qb[0].tc < tc) begin
                checks++; failures++;
                $display("FAIL %s missing at tc=%0d", kname(qb[0].kind), qb[0].tc);
                void'(qb.pop_front());
            end
            if (!u1_oe_n && brg_slot1(tc % 16)) obs(1'b1, K_OE, u1_addr, 8'h00);
            if (!u1_we_n) obs(1'b1, K_WE, u1_addr, u1_wdata);
            if (u1_ack)   obs(1'b1, K_ACK, 17'h0, u1_rdata);
            if (pat_on) begin
                while (qe.size() > 0 && qe[0].tc < tc) begin
                    checks++; failures++;
                    $display("FAIL %s missing at tc=%0d", kname(qe[0].kind), qe[0].tc);
                    void'(qe.pop_front());
                end
                check("u0_setup", u0_setup, (tc % 2) == 0);
                check("u0_strobe", u0_strobe, (tc % 2) == 1);
                check("u1_setup", u1_setup, (tc % 2) == 0);
                if (u0_cpu_en)  obs(1'b0, K_CPU0, 17'h0, 8'h00);
                if (u0_vram_en) obs(1'b0, K_VRAM0, 17'h0, 8'h00);
                if (u0_vrom_en) obs(1'b0, K_VROM0, 17'h0, 8'h00);
                if (u1_vram_en) obs(1'b0, K_VRAM1, 17'h0, 8'h00);
                if (u1_vrom_en) obs(1'b0, K_VROM1, 17'h0, 8'h00);
            end
        end
    end

    task automatic goto_c(input int c);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk); #1;
            if (tc >= 0 && (tc % 16) == c) hit = 1'b1;
        end
        check("goto_c", hit, 1'b1);
    endtask

    initial begin
        int t0;
        // Reset held 5 cycles, model RAM preset meanwhile
        pre_we = 1'b1; pre_addr = 17'h01000; pre_data = 8'h5A;
        repeat (5) @(posedge clk);
        #1 pre_we = 1'b0;
        check("rst_setup", u1_setup, 1'b0);
        check("rst_strobe", u1_strobe, 1'b0);
        check("rst_cpu_en", u1_cpu_en, 1'b0);
        check("rst_vram_en", u1_vram_en, 1'b0);
        check("rst_vrom_en", u1_vrom_en, 1'b0);
        check("rst_ack", u1_ack, 1'b0);
        check("rst_oe_n", u1_oe_n, 1'b1);
        check("rst_we_n", u1_we_n, 1'b1);
        check("rst_addr", u1_addr, 17'h0);
        check("rst_rdata", u1_rdata, 8'h00);
        check("rst_u0_ack", u0_ack, 1'b0);
        check("rst_u0_rdata", u0_rdata, 8'h00);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_setup_c0", u1_setup, 1'b1);
        check("rel_cpu_en_c0", u1_cpu_en, 1'b0);
        @(posedge clk); #1;
        check("rel_cpu_en_c1", u1_cpu_en, 1'b1);
        check("rel_strobe_c1", u0_strobe, 1'b1);

        // Free-run 4 frames: enable pattern of both column modes
        goto_c(0);
        t0 = tc;
        for (int f = 0; f < 4; f++) begin
            push(1'b0, K_CPU0,  t0 + 16*f + 1,  17'h0, 8'h00, 1'b0);
            push(1'b0, K_VRAM0, t0 + 16*f + 5,  17'h0, 8'h00, 1'b0);
            push(1'b0, K_VRAM1, t0 + 16*f + 5,  17'h0, 8'h00, 1'b0);
            push(1'b0, K_VROM0, t0 + 16*f + 7,  17'h0, 8'h00, 1'b0);
            push(1'b0, K_VROM1, t0 + 16*f + 7,  17'h0, 8'h00, 1'b0);
            push(1'b0, K_VRAM1, t0 + 16*f + 11, 17'h0, 8'h00, 1'b0);
            push(1'b0, K_VROM1, t0 + 16*f + 13, 17'h0, 8'h00, 1'b0);
        end
        pat_on = 1'b1;
        repeat (64) @(posedge clk);
        #1 pat_on = 1'b0;

        // CPU write on u0: cpu_we sampled at the slot-0 setup edge
        goto_c(15);
        cpu_we0 = 1'b1; cpu_wdata = 8'hC3;
        goto_c(0);
        check("cpu_wr_c0_we_n", u0_we_n, 1'b1);
        check("cpu_wr_c0_oe_n", u0_oe_n, 1'b1);
        check("cpu_wr_addr", u0_addr, 17'h00100);
        goto_c(1);
        check("cpu_wr_c1_we_n", u0_we_n, 1'b0);
        check("cpu_wr_wdata", u0_wdata, 8'hC3);
        cpu_we0 = 1'b0;

        // Bridge write issued at c=0 -> slot 1
        goto_c(0);
        t0 = tc;
        b_req = 1'b1; b_we = 1'b1; b_addr = 17'h08000; b_wdata = 8'hA5;
        push(1'b1, K_WE,  t0 + 3, 17'h08000, 8'hA5, 1'b1);
        push(1'b1, K_ACK, t0 + 4, 17'h0,     8'h00, 1'b0);
        goto_c(2);
        check("bw_addr_c2", u1_addr, 17'h08000);
        check("bw_we_n_c2", u1_we_n, 1'b1);
        check("bw_oe_n_c2", u1_oe_n, 1'b1);
        goto_c(4);
        b_req = 1'b0;
        check("bw_ram", mem[17'h08000], 8'hA5);

        // Bridge read issued at c=4, held after the first ack -> slot 4 then slot 7
        b_req = 1'b1; b_we = 1'b0; b_addr = 17'h01000; b_wdata = 8'h00;
        push(1'b1, K_OE,  t0 + 8,  17'h01000, 8'h00, 1'b1);
        push(1'b1, K_OE,  t0 + 9,  17'h01000, 8'h00, 1'b1);
        push(1'b1, K_ACK, t0 + 10, 17'h0,     8'h5A, 1'b1);
        push(1'b1, K_OE,  t0 + 14, 17'h01000, 8'h00, 1'b1);
        push(1'b1, K_OE,  t0 + 15, 17'h01000, 8'h00, 1'b1);
        push(1'b1, K_ACK, t0 + 16, 17'h0,     8'h3C, 1'b1);
        goto_c(10);
        pre_we = 1'b1; pre_addr = 17'h01000; pre_data = 8'h3C;
        goto_c(11);
        pre_we = 1'b0;
        check("br_rdata_held", u1_rdata, 8'h5A);
        goto_c(0);
        b_req = 1'b0;

        // Withdrawn request: high during c=3 only, never sampled
        goto_c(3);
        b_req = 1'b1; b_we = 1'b1; b_addr = 17'h02222; b_wdata = 8'h11;
        goto_c(4);
        b_req = 1'b0;
        goto_c(12);
        check("wd_ram", mem[17'h02222], 8'h00);

        // Reset in the strobe cycle of a granted write
        goto_c(0);
        b_req = 1'b1; b_we = 1'b1; b_addr = 17'h00123; b_wdata = 8'h77;
        goto_c(3);
        check("rw_we_n_pre", u1_we_n, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("rw_we_n_async", u1_we_n, 1'b1);
        check("rw_oe_n_async", u1_oe_n, 1'b1);
        check("rw_setup_async", u1_strobe, 1'b0);
        b_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rw_setup_c0", u1_setup, 1'b1);
        check("rw_cpu_en_c0", u1_cpu_en, 1'b0);
        @(posedge clk); #1;
        check("rw_cpu_en_c1", u1_cpu_en, 1'b1);
        goto_c(8);
        check("rw_ram", mem[17'h00123], 8'h00);

        check("qe_drained", qe.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
